// File: rtl/fifo_read_width_upsizer.sv
// -----------------------------------------------------------------------------
// fifo_read_width_upsizer
//
// Sits on the read port of a FIFO, in the same clock domain as that port. It
// pops narrow words and packs RATIO of them into one wide word, which it then
// offers on a valid/ready interface. A flush request pushes out a partially
// filled word, together with the number of lanes that hold data.
//
// The FIFO read port has zero latency: fifo_read_data is the head word while
// fifo_read_empty is low, and fifo_read_enable pops that word in the same cycle.
//
// Ports:
//   clock            single clock, shared with the FIFO read side
//   reset            synchronous, active-high reset
//   fifo_read_enable pop one FIFO word this cycle
//   fifo_read_data   FIFO head word (valid while fifo_read_empty = 0)
//   fifo_read_empty  FIFO empty flag
//   flush            request to emit the current partial word
//   output_valid     a wide word is available
//   output_ready     consumer accepts the word when output_valid & output_ready
//   output_data      packed word; lane 0 (bits [WIDTH-1:0]) is the oldest word
//   output_count     number of valid lanes (1..RATIO) while output_valid = 1
// -----------------------------------------------------------------------------
module fifo_read_width_upsizer #(
    parameter int  WIDTH       = 8,
    parameter int  RATIO       = 4,
    localparam int COUNT_WIDTH = $clog2(RATIO + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     fifo_read_enable,
    input  logic [WIDTH-1:0]         fifo_read_data,
    input  logic                     fifo_read_empty,
    input  logic                     flush,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [WIDTH*RATIO-1:0]   output_data,
    output logic [COUNT_WIDTH-1:0]   output_count
);

    localparam int                      LANE_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_WIDTH-1:0]   LAST_LANE  = LANE_WIDTH'(RATIO - 1);
    localparam logic [COUNT_WIDTH-1:0]  FULL_COUNT = COUNT_WIDTH'(RATIO);

    logic [LANE_WIDTH-1:0]   lane_index_reg,    lane_index_next;
    logic [WIDTH*RATIO-1:0]  accumulator_reg,   accumulator_next;
    logic                    output_valid_reg,  output_valid_next;
    logic [COUNT_WIDTH-1:0]  output_count_reg,  output_count_next;
    logic                    flush_pending_reg, flush_pending_next;

    logic                    can_accept;
    logic                    handoff;
    logic                    pop;
    logic                    complete;
    logic [COUNT_WIDTH-1:0]  filled_lanes;
    logic [RATIO-1:0]        lane_write;

    // A pop is only allowed when the output register is free or is being
    // handed off this cycle, so the accumulator never overwrites a word that
    // the consumer has not yet taken.
    assign can_accept       = !output_valid_reg || output_ready;
    assign handoff          = output_valid_reg && output_ready;
    assign fifo_read_enable = !reset && !fifo_read_empty && can_accept;
    assign pop              = fifo_read_enable;
    assign complete         = pop && (lane_index_reg == LAST_LANE);

    // Lanes already written plus the one written by a same-cycle pop.
    assign filled_lanes = COUNT_WIDTH'(lane_index_reg) + COUNT_WIDTH'(pop);

    // The accumulator doubles as the output register. A handoff clears every
    // lane so that lanes above the last written one read as zero in the next
    // word; a pop in the handoff cycle still lands in lane 0 of that new word.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_write[gi] = pop && (lane_index_reg == LANE_WIDTH'(gi));
            assign accumulator_next[gi*WIDTH +: WIDTH] =
                lane_write[gi] ? fifo_read_data :
                handoff        ? '0             :
                                 accumulator_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        lane_index_next    = lane_index_reg;
        output_valid_next  = output_valid_reg;
        output_count_next  = output_count_reg;
        // Flush pulses are remembered until serviced; pulses arriving while
        // one is already pending merge into it.
        flush_pending_next = flush_pending_reg || flush;

        if (can_accept) begin
            if (handoff) begin
                output_valid_next = 1'b0;
                output_count_next = '0;
            end

            if (pop) begin
                lane_index_next = (lane_index_reg == LAST_LANE) ? '0
                                : lane_index_reg + LANE_WIDTH'(1);
            end

            if (complete) begin
                // A full word wins over a flush serviced in the same cycle.
                output_valid_next = 1'b1;
                output_count_next = FULL_COUNT;
            end else if (flush_pending_reg && (filled_lanes != '0)) begin
                output_valid_next = 1'b1;
                output_count_next = filled_lanes;
                lane_index_next   = '0;
            end

            // Servicing consumes the pending request even when nothing was
            // filled; a flush arriving in this very cycle merges with it.
            if (flush_pending_reg) begin
                flush_pending_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_index_reg    <= '0;
            accumulator_reg   <= '0;
            output_valid_reg  <= 1'b0;
            output_count_reg  <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            lane_index_reg    <= lane_index_next;
            accumulator_reg   <= accumulator_next;
            output_valid_reg  <= output_valid_next;
            output_count_reg  <= output_count_next;
            flush_pending_reg <= flush_pending_next;
        end
    end

    assign output_valid = output_valid_reg;
    assign output_data  = accumulator_reg;
    assign output_count = output_count_reg;

endmodule
